// File: rtl/cpu_pkg.sv
// Shared constants and types for the ALU result stage: branch encodings,
// status bit positions, FSM states and the buffered result word.
package cpu_pkg;

  localparam int DEST_W = 3;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_Z    = 2'b10,
    BR_N    = 2'b11
  } br_type_e;

  localparam int STAT_SIGN  = 3;
  localparam int STAT_ZERO  = 2;
  localparam int STAT_EQUAL = 1;
  localparam int STAT_OVF   = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              wb_en;
  } result_t;

  // Branch condition is taken from the flags arriving with the instruction.
  function automatic logic branch_hit(input logic [1:0] br_type,
                                      input logic       sign,
                                      input logic       zero,
                                      input logic       equal);
    logic hit;
    hit = 1'b0;
    case (br_type)
      BR_EQ:   hit = equal;
      BR_Z:    hit = zero;
      BR_N:    hit = sign;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream (ALU side) and downstream (writeback side) signals of the result
// stage; slave is the stage's view, master the driver/consumer view.
interface alu_result_stage_if;
  import cpu_pkg::*;

  logic              In_valid;
  logic              In_ready;
  logic [DATA_W-1:0] Data_in;
  logic              Sign_in;
  logic              Zero_in;
  logic              Equal_in;
  logic              Ovf_in;
  logic [DEST_W-1:0] Dest_in;
  logic              Wb_en_in;
  logic              Flag_we;
  logic [1:0]        Branch_type;
  logic [DATA_W-1:0] Branch_target;
  logic              Trap_en;

  logic              Out_valid;
  logic              Out_ready;
  logic [DATA_W-1:0] Data_out;
  logic [DEST_W-1:0] Dest_out;
  logic              Wb_en_out;

  logic [3:0]        Status;
  logic              Branch_taken;
  logic [DATA_W-1:0] Branch_pc;
  logic              Trap;
  logic              Trap_ack;

  modport slave (
    input  In_valid, Data_in, Sign_in, Zero_in, Equal_in, Ovf_in, Dest_in,
           Wb_en_in, Flag_we, Branch_type, Branch_target, Trap_en,
           Out_ready, Trap_ack,
    output In_ready, Out_valid, Data_out, Dest_out, Wb_en_out,
           Status, Branch_taken, Branch_pc, Trap
  );

  modport master (
    output In_valid, Data_in, Sign_in, Zero_in, Equal_in, Ovf_in, Dest_in,
           Wb_en_in, Flag_we, Branch_type, Branch_target, Trap_en,
           Out_ready, Trap_ack,
    input  In_ready, Out_valid, Data_out, Dest_out, Wb_en_out,
           Status, Branch_taken, Branch_pc, Trap
  );

endinterface

// File: rtl/result_skid_buf.sv
// Two-entry skid buffer: an output register plus one skid register, FIFO order.
// skid_full_next lets the parent register its ready from the next-state value.
module result_skid_buf
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  result_t in_word,
  input  logic    out_ready,
  output logic    out_valid,
  output result_t out_word,
  output logic    skid_full_next
);

  logic    out_valid_q, out_valid_d;
  result_t out_word_q, out_word_d;
  logic    skid_valid_q, skid_valid_d;
  result_t skid_word_q, skid_word_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    if (!out_valid_q || out_ready) begin
      // Output slot frees up: the older skid entry always goes first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_word_d   = skid_word_q;
        skid_valid_d = push;
        if (push) skid_word_d = in_word;
      end else begin
        out_valid_d = push;
        if (push) out_word_d = in_word;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_word_d  = in_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_word_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_word       = out_word_q;
  assign skid_full_next = skid_valid_d;

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: buffers ALU results, keeps the status register,
// resolves branches from incoming flags and holds an overflow trap until acked.
module alu_result_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  alu_result_stage_if.slave  bus
);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [3:0]        status_q, status_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_pc_q, br_pc_d;

  logic    accept;
  logic    trap_fire;
  logic    push;
  logic    skid_full_next;
  result_t in_word;
  result_t out_word;

  assign accept    = bus.In_valid & in_ready_q;
  assign trap_fire = accept & bus.Ovf_in & bus.Trap_en;
  assign push      = accept & ~trap_fire;

  assign in_word.data  = bus.Data_in;
  assign in_word.dest  = bus.Dest_in;
  assign in_word.wb_en = bus.Wb_en_in;

  result_skid_buf u_skid (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .in_word        (in_word),
    .out_ready      (bus.Out_ready),
    .out_valid      (bus.Out_valid),
    .out_word       (out_word),
    .skid_full_next (skid_full_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (trap_fire)    state_d = ST_TRAP;
      ST_TRAP: if (bus.Trap_ack) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    in_ready_d = ~skid_full_next & (state_d == ST_RUN);

    status_d = status_q;
    if (accept && bus.Flag_we) begin
      status_d[STAT_SIGN]  = bus.Sign_in;
      status_d[STAT_ZERO]  = bus.Zero_in;
      status_d[STAT_EQUAL] = bus.Equal_in;
      status_d[STAT_OVF]   = bus.Ovf_in;
    end

    // A trapping instruction is squashed, so it can never redirect the PC.
    br_taken_d = push & branch_hit(bus.Branch_type, bus.Sign_in,
                                   bus.Zero_in, bus.Equal_in);
    br_pc_d    = br_taken_d ? bus.Branch_target : br_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      in_ready_q <= 1'b0;
      status_q   <= '0;
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      status_q   <= status_d;
      br_taken_q <= br_taken_d;
      br_pc_q    <= br_pc_d;
    end
  end

  assign bus.In_ready     = in_ready_q;
  assign bus.Data_out     = out_word.data;
  assign bus.Dest_out     = out_word.dest;
  assign bus.Wb_en_out    = out_word.wb_en;
  assign bus.Status       = status_q;
  assign bus.Branch_taken = br_taken_q;
  assign bus.Branch_pc    = br_pc_q;
  assign bus.Trap         = (state_q == ST_TRAP);

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-to-writeback pipeline stage that sits directly downstream of the 16-bit ALU. It captures the ALU result and its flags with a valid/ready handshake and a two-entry skid buffer. It maintains the architectural status register, resolves conditional branches from the incoming flags, and raises an overflow trap that stalls the stage until it is acknowledged.

## Interface
- DEST_W, 3, destination register index width (8 GPRs)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- In_valid  in  1  upstream holds an ALU result
- In_ready  out  1  stage can accept; registered
- Data_in  in  16  ALU Data_out
- Sign_in, Zero_in, Equal_in, Ovf_in  in  1 each  ALU flags
- Dest_in  in  DEST_W  destination register
- Wb_en_in  in  1  result is written back
- Flag_we  in  1  update status register
- Branch_type  in  2  00 none, 01 BEQ (equal), 10 BZ (zero), 11 BN (sign)
- Branch_target  in  16  target PC
- Trap_en  in  1  overflow traps for this instruction
- Out_valid  out  1  writeback entry valid
- Out_ready  in  1  writeback accepts
- Data_out  out  16  result
- Dest_out  out  DEST_W  destination
- Wb_en_out  out  1  write enable
- Status  out  4  {sign, zero, equal, overflow}
- Branch_taken  out  1  one-cycle pulse
- Branch_pc  out  16  valid while Branch_taken
- Trap  out  1  overflow trap pending
- Trap_ack  in  1  clears trap

## Operation
- Accept = In_valid & In_ready. An accepted entry goes to the output register if it is empty or draining (Out_ready); otherwise it goes to the skid register. FIFO order is always preserved.
- In_ready = skid empty & state RUN. In_ready is registered, so it deasserts the cycle after the skid fills.
- Status register: loads {Sign_in, Zero_in, Equal_in, Ovf_in} on Accept when Flag_we = 1. It holds otherwise.
- Branch condition uses the incoming flags, not Status:
  - BEQ: Equal_in
  - BZ: Zero_in
  - BN: Sign_in
  - On Accept with a true condition, Branch_taken pulses with Branch_pc = Branch_target. The branch entry is still forwarded.
- FSM states are RUN and TRAP.
  - RUN to TRAP on Accept with Ovf_in & Trap_en. The trapping entry is dropped (never appears on Out_valid). Status is still updated if Flag_we = 1.
  - TRAP to RUN on Trap_ack. Trap_ack in RUN is ignored.
- In TRAP, In_ready = 0 and buffered entries drain normally.
- A trapping instruction never produces Branch_taken.
- Reset mid-operation discards both buffer entries and any pending trap.

## Timing
- Reset values:
  - Out_valid = 0, Data_out = 0, Dest_out = 0, Wb_en_out = 0
  - Status = 0, Branch_taken = 0, Branch_pc = 0, Trap = 0
  - In_ready = 0 during reset and 1 from the first cycle after reset
  - State = RUN
- Latency: Accept at cycle N gives Out_valid with the data at N+1, when the output register was free or drained at N.
- Branch_taken and Branch_pc are registered: asserted in cycle N+1 for exactly one cycle.
- Trap is high from N+1. In_ready stays 0 through the Trap_ack cycle and returns to 1 the cycle after Trap_ack.
- Out_valid and data stay stable while Out_valid & !Out_ready.
- Simultaneous Accept and Out_ready with both entries full is impossible, because In_ready is already 0.
- With one entry full plus Accept plus Out_ready, the new entry moves into the output register and the skid stays empty.

## Structure
- Shared cpu_pkg holds:
  - Branch_type encodings (BR_NONE, BR_EQ, BR_Z, BR_N)
  - status bit positions
  - the DEST_W constant
  - FSM state encodings (ST_RUN, ST_TRAP)
- One sub-module, result_skid_buf: a 2-entry valid/ready skid buffer over the packed {Data, Dest, Wb_en} word. The flag, branch and trap logic stays in the top module.

## Test plan
- Back-to-back stream, Out_ready = 1: Data_in 0x0001..0x0004 on consecutive cycles gives Data_out 0x0001..0x0004 one cycle later each, and In_ready stays 1.
- Backpressure: Out_ready = 0 with 3 offered entries. Entries 1–2 are accepted, In_ready drops after the 2nd accept, and entry 3 is held upstream. Raising Out_ready delivers 1, 2, 3 in order with no loss or duplicate.
- Status: accept Flag_we = 1 with flags {1,0,0,0}, then Flag_we = 0 with {0,1,1,1}. Status = 4'b1000 after both.
- Branch: BEQ with Equal_in = 1 and target 0x0040 gives Branch_taken for one cycle with Branch_pc = 0x0040. BZ with Zero_in = 0 gives no pulse.
- Trap: Ovf_in = 1 and Trap_en = 1 on Data_in 0x8000.
  - The entry never reaches Out_valid, Trap = 1 and In_ready = 0.
  - Trap_ack pulse clears Trap, and In_ready = 1 the next cycle.
  - Ovf_in = 1 with Trap_en = 0 passes through normally.
- Reset with both entries full and Trap set: all outputs return to their reset values on the next cycle, and the buffered data is never emitted.
